// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiters.
// The optional statistics outputs of uart_tx_arbiter are enabled by UART_TX_ARB_STATS_EN.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_N_REQ         = 4;
  localparam int DEF_START_TIMEOUT = 4;
  localparam int DEF_GAP_CYCLES    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_t;

  // Counter width able to hold 0..limit without wrapping.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1, modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            pos;
  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      pos  = (int'(ptr_i) + i) % N;
      cand = IW'(pos);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// Define UART_TX_ARB_STATS_EN to add the frame_cnt_o / last_src_o statistics outputs.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      tx_e_o,
  output logic [BYTE_W-1:0]         tx_d_o,
  input  logic                      tx_busy_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o,
  output logic                      start_err_o
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [15:0]               frame_cnt_o,
  output logic [$clog2(N_REQ)-1:0]  last_src_o
`endif
);

  localparam int IW        = $clog2(N_REQ);
  localparam int CNT_LIMIT = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW        = cnt_width(CNT_LIMIT);
  localparam arb_state_t POST_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              tx_e_q, tx_e_d;
  logic [BYTE_W-1:0] tx_d_q, tx_d_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [IW-1:0]     last_src_q, last_src_d;
`endif

  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              can_grant;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A foreign user of the transmitter (busy while idle) blocks new grants.
  assign can_grant   = (state_q == ST_IDLE) && !tx_busy_i && pick_any;
  assign req_ready_o = can_grant ? pick_grant : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    tx_e_d  = 1'b0;
    tx_d_d  = tx_d_q;
    grant_d = grant_q;
    err_d   = err_q;
`ifdef UART_TX_ARB_STATS_EN
    frame_cnt_d = frame_cnt_q;
    last_src_d  = last_src_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          tx_d_d  = req_data_i[int'(pick_idx)*BYTE_W +: BYTE_W];
          grant_d = pick_grant;
          ptr_d   = pick_idx;
          tx_e_d  = 1'b1;
          state_d = ST_LAUNCH;
`ifdef UART_TX_ARB_STATS_EN
          last_src_d = pick_idx;
`endif
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = POST_FRAME;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          cnt_d   = '0;
          state_d = POST_FRAME;
`ifdef UART_TX_ARB_STATS_EN
          frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      grant_d = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      tx_e_q  <= 1'b0;
      tx_d_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_TX_ARB_STATS_EN
      frame_cnt_q <= '0;
      last_src_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      tx_e_q  <= tx_e_d;
      tx_d_q  <= tx_d_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef UART_TX_ARB_STATS_EN
      frame_cnt_q <= frame_cnt_d;
      last_src_q  <= last_src_d;
`endif
    end
  end

  assign tx_e_o      = tx_e_q;
  assign tx_d_o      = tx_d_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign start_err_o = err_q;
`ifdef UART_TX_ARB_STATS_EN
  assign frame_cnt_o = frame_cnt_q;
  assign last_src_o  = last_src_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner sequences and a randomized run.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] base;
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_e, tx_busy, busy, start_err;
  logic [7:0]  tx_d;

  logic [3:0]  g_valid, g_ready, g_grant;
  logic [31:0] g_data;
  logic        g_tx_e, g_tx_busy, g_busy, g_start_err;
  logic [7:0]  g_tx_d;
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] frame_cnt, g_frame_cnt;
  logic [1:0]  last_src, g_last_src;
`endif

  int total = 0;
  int bad   = 0;

  vec_t       tbl [10];
  logic [3:0] vld;
  logic [7:0] byt [4];
  int         model_last, next_idle, grant_cyc, launch_cyc, busy_left, acc_k, err_from, d, w;
  logic [7:0] exp_byte;
  logic [3:0] exp_ready;
  logic       in_frame;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_e_o(tx_e), .tx_d_o(tx_d), .tx_busy_i(tx_busy),
    .grant_o(grant), .busy_o(busy), .start_err_o(start_err)
`ifdef UART_TX_ARB_STATS_EN
    , .frame_cnt_o(frame_cnt), .last_src_o(last_src)
`endif
  );

  uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(4), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .reset(reset), .req_valid_i(g_valid), .req_data_i(g_data),
    .req_ready_o(g_ready), .tx_e_o(g_tx_e), .tx_d_o(g_tx_d), .tx_busy_i(g_tx_busy),
    .grant_o(g_grant), .busy_o(g_busy), .start_err_o(g_start_err)
`ifdef UART_TX_ARB_STATS_EN
    , .frame_cnt_o(g_frame_cnt), .last_src_o(g_last_src)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycleStart();
    @(posedge clk);
    #1;
  endtask

  task automatic cycleSample();
    @(negedge clk);
  endtask

  // Acts as uart_tx after launch: busy for d cycles, then one cycle low.
  task automatic serveFrame(input int cycles);
    repeat (cycles) begin
      cycleStart(); tx_busy = 1'b1; cycleSample();
    end
    cycleStart(); tx_busy = 1'b0; cycleSample();
  endtask

  task automatic applyStimulus(input vec_t v);
    cycleStart();
    req_valid = v.valid;
    for (int k = 0; k < 4; k++) req_data[8*k +: 8] = v.base + 8'(k);
    cycleSample();
    checkOutput("tbl_ready", 32'(req_ready), 32'(v.exp_ready));
    cycleStart(); cycleSample();
    checkOutput("tbl_ready_pulse", 32'(req_ready), 32'(0));
    checkOutput("tbl_tx_e", 32'(tx_e), 32'(1));
    checkOutput("tbl_tx_d", 32'(tx_d), 32'(v.exp_data));
    checkOutput("tbl_grant", 32'(grant), 32'(v.exp_ready));
    serveFrame(2);
  endtask

  // Smallest valid index above the last winner, otherwise the smallest valid index.
  function automatic int model_winner(input logic [3:0] v, input int last);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (v[k] && k > last && r < 0) r = k;
    for (int k = 0; k < 4; k++) if (v[k] && r < 0) r = k;
    return r;
  endfunction

  initial begin
    tbl[0] = '{4'b1111, 8'h10, 4'b0001, 8'h10};
    tbl[1] = '{4'b1111, 8'h10, 4'b0010, 8'h11};
    tbl[2] = '{4'b1111, 8'h10, 4'b0100, 8'h12};
    tbl[3] = '{4'b1111, 8'h10, 4'b1000, 8'h13};
    tbl[4] = '{4'b1111, 8'h10, 4'b0001, 8'h10};
    tbl[5] = '{4'b0101, 8'h20, 4'b0100, 8'h22};
    tbl[6] = '{4'b1001, 8'h30, 4'b1000, 8'h33};
    tbl[7] = '{4'b0110, 8'h40, 4'b0010, 8'h41};
    tbl[8] = '{4'b0010, 8'h50, 4'b0010, 8'h51};
    tbl[9] = '{4'b0001, 8'hA0, 4'b0001, 8'hA0};

    reset = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    g_valid = '0; g_data = '0; g_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cycleSample();
    checkOutput("rst_ready", 32'(req_ready), 32'(0));
    checkOutput("rst_tx_e", 32'(tx_e), 32'(0));
    checkOutput("rst_tx_d", 32'(tx_d), 32'(0));
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_err", 32'(start_err), 32'(0));

    $display("[TB] single requester");
    cycleStart(); req_valid = 4'b0100; req_data[23:16] = 8'h5A; cycleSample();
    checkOutput("single_ready", 32'(req_ready), 32'(4'b0100));
    cycleStart(); req_valid = '0; cycleSample();
    checkOutput("single_ready_pulse", 32'(req_ready), 32'(0));
    checkOutput("single_tx_e", 32'(tx_e), 32'(1));
    checkOutput("single_tx_d", 32'(tx_d), 32'(8'h5A));
    checkOutput("single_grant", 32'(grant), 32'(4'b0100));
    for (int i = 0; i < 10; i++) begin
      cycleStart(); tx_busy = 1'b1; cycleSample();
      checkOutput("single_tx_e_low", 32'(tx_e), 32'(0));
      checkOutput("single_hold_d", 32'(tx_d), 32'(8'h5A));
    end
    cycleStart(); tx_busy = 1'b0; cycleSample();
    checkOutput("single_busy_at_fall", 32'(busy), 32'(1));
    cycleStart(); cycleSample();
    checkOutput("single_busy_after_fall", 32'(busy), 32'(0));
    checkOutput("single_grant_cleared", 32'(grant), 32'(0));

    $display("[TB] arbitration table");
    cycleStart(); reset = 1'b1; cycleSample();
    cycleStart(); reset = 1'b0; cycleSample();
    for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);

    $display("[TB] start timeout");
    cycleStart(); req_valid = 4'b0010; req_data[15:8] = 8'h77; cycleSample();
    checkOutput("to_ready", 32'(req_ready), 32'(4'b0010));
    cycleStart(); req_valid = '0; cycleSample();
    checkOutput("to_tx_d", 32'(tx_d), 32'(8'h77));
    for (int i = 0; i < 4; i++) begin
      cycleStart(); cycleSample();
      checkOutput("to_err_early", 32'(start_err), 32'(0));
      checkOutput("to_busy", 32'(busy), 32'(1));
    end
    cycleStart(); req_valid = 4'b1000; req_data[31:24] = 8'h88; cycleSample();
    checkOutput("to_err_set", 32'(start_err), 32'(1));
    checkOutput("to_idle", 32'(busy), 32'(0));
    checkOutput("to_next_ready", 32'(req_ready), 32'(4'b1000));
    cycleStart(); req_valid = '0; cycleSample();
    checkOutput("to_next_tx_d", 32'(tx_d), 32'(8'h88));
    serveFrame(1);

    $display("[TB] foreign busy in idle");
    cycleStart(); tx_busy = 1'b1; req_valid = 4'b0010; req_data[15:8] = 8'h3C; cycleSample();
    checkOutput("fb_blocked", 32'(req_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cycleStart(); cycleSample();
      checkOutput("fb_blocked", 32'(req_ready), 32'(0));
    end
    cycleStart(); tx_busy = 1'b0; cycleSample();
    checkOutput("fb_ready", 32'(req_ready), 32'(4'b0010));
    cycleStart(); req_valid = '0; cycleSample();
    checkOutput("fb_tx_d", 32'(tx_d), 32'(8'h3C));
    serveFrame(2);

    $display("[TB] reset mid-frame");
    cycleStart(); req_valid = 4'b1001; req_data[7:0] = 8'hC0; req_data[31:24] = 8'hC3; cycleSample();
    checkOutput("rmf_ready", 32'(req_ready), 32'(4'b1000));
    cycleStart(); cycleSample();
    checkOutput("rmf_tx_d", 32'(tx_d), 32'(8'hC3));
    repeat (2) begin
      cycleStart(); tx_busy = 1'b1; cycleSample();
    end
    checkOutput("rmf_busy", 32'(busy), 32'(1));
    cycleStart(); reset = 1'b1; cycleSample();
    cycleStart(); reset = 1'b0; cycleSample();
    checkOutput("rmf_ready0", 32'(req_ready), 32'(0));
    checkOutput("rmf_tx_e0", 32'(tx_e), 32'(0));
    checkOutput("rmf_tx_d0", 32'(tx_d), 32'(0));
    checkOutput("rmf_grant0", 32'(grant), 32'(0));
    checkOutput("rmf_busy0", 32'(busy), 32'(0));
    checkOutput("rmf_err0", 32'(start_err), 32'(0));
    cycleStart(); tx_busy = 1'b0; cycleSample();
    checkOutput("rmf_first", 32'(req_ready), 32'(4'b0001));
    cycleStart(); req_valid = '0; cycleSample();
    checkOutput("rmf_first_d", 32'(tx_d), 32'(8'hC0));
    serveFrame(1);

    $display("[TB] randomized run");
    model_last = 0; next_idle = 0; grant_cyc = -1; launch_cyc = -1;
    busy_left = 0; acc_k = -1; err_from = 32'h7fffffff; vld = '0;
    w = 0; exp_byte = '0;
    for (int k = 0; k < 4; k++) byt[k] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      cycleStart();
      if (acc_k >= 0) begin
        vld[acc_k] = 1'($urandom_range(0, 1));
        byt[acc_k] = 8'($urandom);
        acc_k = -1;
      end
      for (int k = 0; k < 4; k++) begin
        if (!vld[k]) begin
          if ($urandom_range(0, 3) == 0) begin vld[k] = 1'b1; byt[k] = 8'($urandom); end
        end else if ($urandom_range(0, 39) == 0) begin
          vld[k] = 1'b0;
        end
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      req_valid = vld;
      for (int k = 0; k < 4; k++) req_data[8*k +: 8] = byt[k];
      cycleSample();

      checkOutput("rnd_tx_e", 32'(tx_e), 32'(cyc == launch_cyc));
      if (cyc == launch_cyc) begin
        checkOutput("rnd_tx_d", 32'(tx_d), 32'(exp_byte));
        if ($urandom_range(0, 7) == 0) begin
          next_idle = cyc + 1 + 4;
          if (err_from == 32'h7fffffff) err_from = next_idle;
        end else begin
          d = int'($urandom_range(1, 6));
          busy_left = d;
          next_idle = cyc + 2 + d;
        end
      end
      in_frame = (cyc > grant_cyc) && (cyc < next_idle);
      checkOutput("rnd_busy", 32'(busy), 32'(in_frame));
      checkOutput("rnd_grant", 32'(grant), in_frame ? 32'(1 << model_last) : 32'(0));
      checkOutput("rnd_err", 32'(start_err), 32'(cyc >= err_from));
      exp_ready = '0;
      if (cyc >= next_idle && !tx_busy && vld != '0) begin
        w = model_winner(vld, model_last);
        exp_ready = 4'(1 << w);
      end
      checkOutput("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
        model_last = w;
        grant_cyc  = cyc;
        launch_cyc = cyc + 1;
        exp_byte   = byt[w];
        acc_k      = w;
        next_idle  = 32'h7fffffff;
      end
    end
    cycleStart(); req_valid = '0; tx_busy = 1'b0; cycleSample();

    $display("[TB] inter-frame gap");
    cycleStart(); g_valid = 4'b0001; g_data[7:0] = 8'h61; cycleSample();
    checkOutput("gap_ready0", 32'(g_ready), 32'(4'b0001));
    cycleStart(); g_valid = '0; cycleSample();
    checkOutput("gap_tx_d0", 32'(g_tx_d), 32'(8'h61));
    repeat (2) begin
      cycleStart(); g_tx_busy = 1'b1; cycleSample();
    end
    cycleStart(); g_tx_busy = 1'b0; g_valid = 4'b0010; g_data[15:8] = 8'h62; cycleSample();
    checkOutput("gap_fall_ready", 32'(g_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cycleStart(); cycleSample();
      checkOutput("gap_hold_ready", 32'(g_ready), 32'(0));
      checkOutput("gap_busy", 32'(g_busy), 32'(1));
    end
    cycleStart(); cycleSample();
    checkOutput("gap_ready1", 32'(g_ready), 32'(4'b0010));
    cycleStart(); g_valid = '0; cycleSample();
    checkOutput("gap_tx_d1", 32'(g_tx_d), 32'(8'h62));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
